dmem_access_ctrl: RTL and testbench

DMEM_ACCESS_CTRL -- requirements
Module: dmem_access_ctrl

---
 rtl/dmem_access_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory access controller: one-transaction FSM, load extension, store replication.
// Define ALIGN_CHECK_EN to reject misaligned accesses via adelM/adesM; otherwise the address is forced aligned.
`ifndef LB
`define LB  6'b100000
`endif
`ifndef LH
`define LH  6'b100001
`endif
`ifndef LW
`define LW  6'b100011
`endif
`ifndef LBU
`define LBU 6'b100100
`endif
`ifndef LHU
`define LHU 6'b100101
`endif
`ifndef SB
`define SB  6'b101000
`endif
`ifndef SH
`define SH  6'b101001
`endif
`ifndef SW
`define SW  6'b101011
`endif

module dmem_access_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  opM,
    input  logic        memenM,
    input  logic [31:0] addrM,
    input  logic [31:0] wdataM,
    input  logic        flushM,
    output logic        stallM,
    output logic [31:0] rdataM,
    output logic        adelM,
    output logic        adesM,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

    state_t      state, state_nxt;
    logic        flush_pend;
    logic [5:0]  op_lat;
    logic [31:0] addr_lat;
    logic [31:0] wdata_lat;
    logic [31:0] result_lat;
    logic        addr_err;
    logic        start;
    logic        req_err;
    logic        complete;
    logic        flushed;

    function automatic logic [1:0] size_of(input logic [5:0] op);
        case (op)
            `LB, `LBU, `SB: return 2'd0;
            `LH, `LHU, `SH: return 2'd1;
            default:        return 2'd2;
        endcase
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return (op == `SB) || (op == `SH) || (op == `SW);
    endfunction

    function automatic logic misaligned(input logic [5:0] op, input logic [1:0] lo);
        case (size_of(op))
            2'd1:    return lo[0];
            2'd2:    return lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] align_addr(input logic [5:0] op, input logic [31:0] a);
        case (size_of(op))
            2'd1:    return {a[31:1], 1'b0};
            2'd2:    return {a[31:2], 2'b00};
            default: return a;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [5:0] op, input logic [31:0] d);
        case (size_of(op))
            2'd0:    return {4{d[7:0]}};
            2'd1:    return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] load_ext(input logic [5:0] op, input logic [1:0] lo,
                                             input logic [31:0] raw);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        b = raw[{lo, 3'b000} +: 8];
        h = lo[1] ? raw[31:16] : raw[15:0];
        case (op)
            `LB:     return {{24{b[7]}}, b};
            `LBU:    return {24'b0, b};
            `LH:     return {{16{h[15]}}, h};
            `LHU:    return {16'b0, h};
            default: return raw;
        endcase
    endfunction

`ifdef ALIGN_CHECK_EN
    assign addr_err = misaligned(opM, addrM[1:0]);
`else
    assign addr_err = 1'b0;
`endif

    assign start    = (state == IDLE) && memenM && !flushM && !addr_err;
    assign req_err  = (state == IDLE) && memenM && !flushM && addr_err;
    assign complete = ((state == ADDR) && data_addr_ok && data_data_ok) ||
                      ((state == DATA) && data_data_ok);
    assign flushed  = flush_pend || flushM;

    // state register and flush bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            flush_pend <= 1'b0;
        end else begin
            state <= state_nxt;
            if ((state == ADDR) || (state == DATA))
                flush_pend <= flush_pend | flushM;
            else
                flush_pend <= 1'b0;
        end
    end

    // transaction payload; gated by state so no reset is needed
    always_ff @(posedge clk) begin
        if (start) begin
            op_lat    <= opM;
            addr_lat  <= addrM;
            wdata_lat <= wdataM;
        end
        if (complete)
            result_lat <= is_store(op_lat) ? 32'b0 : load_ext(op_lat, addr_lat[1:0], data_rdata);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = ADDR;
            ADDR: begin
                if (data_addr_ok) begin
                    if (data_data_ok)
                        state_nxt = flushed ? IDLE : DONE;
                    else
                        state_nxt = DATA;
                end
            end
            DATA: if (data_data_ok) state_nxt = flushed ? IDLE : DONE;
            DONE: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        stallM     = 1'b0;
        rdataM     = 32'b0;
        adelM      = 1'b0;
        adesM      = 1'b0;
        data_req   = 1'b0;
        data_wr    = 1'b0;
        data_size  = 2'd0;
        data_addr  = 32'b0;
        data_wdata = 32'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    stallM = start;
                    adelM  = req_err && !is_store(opM);
                    adesM  = req_err && is_store(opM);
                end
                ADDR: begin
                    stallM     = 1'b1;
                    data_req   = 1'b1;
                    data_wr    = is_store(op_lat);
                    data_size  = size_of(op_lat);
                    data_addr  = align_addr(op_lat, addr_lat);
                    data_wdata = store_data(op_lat, wdata_lat);
                end
                DATA: stallM = 1'b1;
                DONE: rdataM = result_lat;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl: reset, load extension, store replication, flush, reset abort.
`ifndef LB
`define LB  6'b100000
`endif
`ifndef LH
`define LH  6'b100001
`endif
`ifndef LW
`define LW  6'b100011
`endif
`ifndef LBU
`define LBU 6'b100100
`endif
`ifndef LHU
`define LHU 6'b100101
`endif
`ifndef SB
`define SB  6'b101000
`endif
`ifndef SH
`define SH  6'b101001
`endif
`ifndef SW
`define SW  6'b101011
`endif

module tb_dmem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  opM;
    logic        memenM;
    logic [31:0] addrM;
    logic [31:0] wdataM;
    logic        flushM;
    logic        stallM;
    logic [31:0] rdataM;
    logic        adelM;
    logic        adesM;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    int vectors     = 0;
    int miscompares = 0;
    int stall_cnt;

    dmem_access_ctrl dut (
        .clk(clk), .rst(rst), .opM(opM), .memenM(memenM), .addrM(addrM),
        .wdataM(wdataM), .flushM(flushM), .stallM(stallM), .rdataM(rdataM),
        .adelM(adelM), .adesM(adesM), .data_req(data_req), .data_wr(data_wr),
        .data_size(data_size), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    // addr_ok on the first ADDR cycle, data_ok one cycle later
    task automatic access(input string tag, input logic [5:0] op, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata,
                          input logic [31:0] exp_addr, input logic [1:0] exp_size,
                          input logic exp_wr, input logic [31:0] exp_wdata,
                          input logic [31:0] exp_rdata);
        opM = op; addrM = addr; wdataM = wdata; memenM = 1'b1;
        settle();
        chk({tag, "/idle_stall"}, stallM, 1);
        chk({tag, "/idle_req"}, data_req, 0);
        chk({tag, "/adel"}, adelM, 0);
        chk({tag, "/ades"}, adesM, 0);
        adv();
        data_addr_ok = 1'b1;
        settle();
        chk({tag, "/req"}, data_req, 1);
        chk({tag, "/addr"}, data_addr, exp_addr);
        chk({tag, "/size"}, data_size, exp_size);
        chk({tag, "/wr"}, data_wr, exp_wr);
        chk({tag, "/wdata"}, data_wdata, exp_wdata);
        adv();
        data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = rdata;
        settle();
        chk({tag, "/data_stall"}, stallM, 1);
        chk({tag, "/data_req"}, data_req, 0);
        adv();
        data_data_ok = 1'b0;
        settle();
        chk({tag, "/done_stall"}, stallM, 0);
        chk({tag, "/rdata"}, rdataM, exp_rdata);
        adv();
        memenM = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; opM = `LW; memenM = 1'b1; addrM = 32'h100; wdataM = 32'h0; flushM = 1'b0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;

        // reset: every output low even with a request presented
        adv();
        settle();
        chk("rst/stall", stallM, 0);
        chk("rst/rdata", rdataM, 0);
        chk("rst/adel", adelM, 0);
        chk("rst/ades", adesM, 0);
        chk("rst/req", data_req, 0);
        chk("rst/wr", data_wr, 0);
        chk("rst/size", data_size, 0);
        chk("rst/addr", data_addr, 0);
        chk("rst/wdata", data_wdata, 0);
        adv();
        rst = 1'b0; memenM = 1'b0;
        settle();
        chk("post_rst/stall", stallM, 0);
        adv();

        // LB at 3, addr_ok then data_ok, stall counted over the transaction
        stall_cnt = 0;
        opM = `LB; addrM = 32'h3; memenM = 1'b1;
        settle(); if (stallM) stall_cnt++;
        adv(); data_addr_ok = 1'b1;
        settle(); if (stallM) stall_cnt++;
        chk("lb/addr", data_addr, 32'h3);
        chk("lb/size", data_size, 0);
        adv(); data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h80FF1234;
        settle(); if (stallM) stall_cnt++;
        adv(); data_data_ok = 1'b0;
        settle(); if (stallM) stall_cnt++;
        chk("lb/rdata", rdataM, 32'hFFFFFF80);
        chk("lb/stall_cycles", stall_cnt, 3);
        adv(); memenM = 1'b0;
        settle();
        chk("lb/rdata_after", rdataM, 0);
        adv();

        // SH at 2 held through a 4-cycle addr_ok wait
        opM = `SH; addrM = 32'h2; wdataM = 32'h0000BEEF; memenM = 1'b1;
        adv();
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("sh/wait_req", data_req, 1);
            chk("sh/wait_wr", data_wr, 1);
            chk("sh/wait_size", data_size, 1);
            chk("sh/wait_wdata", data_wdata, 32'hBEEFBEEF);
            chk("sh/wait_addr", data_addr, 32'h2);
            adv();
        end
        data_addr_ok = 1'b1;
        settle();
        chk("sh/ok_wdata", data_wdata, 32'hBEEFBEEF);
        adv(); data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hDEADBEEF;
        settle();
        chk("sh/data_stall", stallM, 1);
        adv(); data_data_ok = 1'b0;
        settle();
        chk("sh/done_rdata", rdataM, 0);
        chk("sh/done_stall", stallM, 0);
        adv(); memenM = 1'b0;

        access("sb", `SB, 32'h1, 32'h123456A5, 32'h0, 32'h1, 2'd0, 1'b1, 32'hA5A5A5A5, 32'h0);
        access("sw", `SW, 32'h8, 32'hDEADBEEF, 32'h0, 32'h8, 2'd2, 1'b1, 32'hDEADBEEF, 32'h0);
        access("lbu", `LBU, 32'h1, 32'h0, 32'h0000F000, 32'h1, 2'd0, 1'b0, 32'h0, 32'h000000F0);

        // LHU with same-cycle handshake, then LH back-to-back
        opM = `LHU; addrM = 32'h10; memenM = 1'b1;
        adv(); data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h1234ABCD;
        settle();
        chk("lhu/addr", data_addr, 32'h10);
        adv(); data_addr_ok = 1'b0; data_data_ok = 1'b0;
        settle();
        chk("lhu/rdata", rdataM, 32'h0000ABCD);
        chk("lhu/done_stall", stallM, 0);
        chk("lhu/done_req", data_req, 0);
        adv();
        opM = `LH; addrM = 32'h2;
        settle();
        chk("lh/idle_stall", stallM, 1);
        chk("lh/idle_req", data_req, 0);
        adv(); data_addr_ok = 1'b1;
        settle();
        chk("lh/addr", data_addr, 32'h2);
        adv(); data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h80001234;
        adv(); data_data_ok = 1'b0;
        settle();
        chk("lh/rdata", rdataM, 32'hFFFF8000);
        adv(); memenM = 1'b0;

`ifdef ALIGN_CHECK_EN
        opM = `LW; addrM = 32'h6; memenM = 1'b1;
        settle();
        chk("lw6/adel", adelM, 1);
        chk("lw6/ades", adesM, 0);
        chk("lw6/stall", stallM, 0);
        adv();
        settle();
        chk("lw6/req", data_req, 0);
        adv();
        opM = `SH; addrM = 32'h1;
        settle();
        chk("sh1/ades", adesM, 1);
        chk("sh1/stall", stallM, 0);
        adv(); memenM = 1'b0;
`else
        access("lw6", `LW, 32'h6, 32'h0, 32'hCAFEF00D, 32'h4, 2'd2, 1'b0, 32'h0, 32'hCAFEF00D);
`endif

        // flush in IDLE blocks the request
        opM = `LW; addrM = 32'h40; memenM = 1'b1; flushM = 1'b1;
        settle();
        chk("flush_idle/stall", stallM, 0);
        adv(); flushM = 1'b0; memenM = 1'b0;
        settle();
        chk("flush_idle/req", data_req, 0);
        adv();

        // flush during DATA: completes, skips DONE, result discarded
        opM = `LW; addrM = 32'h20; memenM = 1'b1;
        adv(); data_addr_ok = 1'b1;
        adv(); data_addr_ok = 1'b0; flushM = 1'b1;
        settle();
        chk("flush_data/req", data_req, 0);
        chk("flush_data/stall", stallM, 1);
        adv(); flushM = 1'b0; memenM = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h11111111;
        settle();
        chk("flush_data/ok_stall", stallM, 1);
        adv(); data_data_ok = 1'b0;
        settle();
        chk("flush_data/after_stall", stallM, 0);
        chk("flush_data/after_rdata", rdataM, 0);
        chk("flush_data/after_req", data_req, 0);
        adv();
        settle();
        chk("flush_data/next_rdata", rdataM, 0);
        adv();

        // reset mid-transaction, then a late data_ok
        opM = `LW; addrM = 32'h44; memenM = 1'b1;
        adv(); data_addr_ok = 1'b1;
        adv(); data_addr_ok = 1'b0; rst = 1'b1;
        settle();
        chk("rst_mid/stall", stallM, 0);
        adv(); rst = 1'b0; memenM = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h55555555;
        settle();
        chk("rst_mid/late_stall", stallM, 0);
        chk("rst_mid/late_req", data_req, 0);
        adv(); data_data_ok = 1'b0;
        settle();
        chk("rst_mid/rdata", rdataM, 0);
        chk("rst_mid/stall_idle", stallM, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
